program_loader: RTL
===================

// Module: program_loader
// PURPOSE
//   Byte-stream program loader directly upstream of icache. Receives a length-prefixed
//   stream of bytes (e.g. from a UART receiver), assembles 16-bit instructions and writes
//   them sequentially into icache via download_program / instruction_index / instruction.
//   Holds download_program high for the whole transfer so the pipeline clock (clk2) is gated.
// PARAMETERS
//   ADDR_W     8    width of instruction_index; icache depth = 2**ADDR_W words
//   MAX_WORDS  256  largest accepted word count, must be <= 2**ADDR_W
// PORTS
//   clk                input   1       system clock, all logic on rising edge
//   reset              input   1       asynchronous, active-high reset
//   start              input   1       one-cycle pulse: begin a new load
//   rx_valid           input   1       rx_data holds a valid byte
//   rx_data            input   8       incoming byte
//   rx_ready           output  1       loader accepts byte this cycle (xfer = rx_valid & rx_ready)
//   download_program   output  1       high while a load is in progress (gates CPU clock)
//   wr_en              output  1       one-cycle icache write strobe
//   instruction_index  output  ADDR_W  icache word address for the current write
//   instruction        output  16      instruction word to write
//   done               output  1       level: last load completed successfully
//   error              output  1       level: last load aborted (bad length / checksum)
// BEHAVIOUR
//   - Reset: state IDLE; rx_ready, download_program, wr_en, done, error = 0;
//     instruction_index = 0; instruction = 0; word counter = 0.
//   - Stream format: LEN_LO, LEN_HI (N, 16-bit little-endian), then N words, each LO then HI.
//   - FSM: IDLE -start-> LEN_LO -xfer-> LEN_HI -xfer-> DATA_LO -xfer-> DATA_HI -xfer->
//     DATA_LO (more words) | DONE (last word; CHECK when checksum enabled); ERR on fault.
//   - IDLE/DONE/ERR: rx_ready = 0; start moves to LEN_LO, clears done/error, index = 0,
//     asserts download_program in the cycle after start. start in any other state ignored.
//   - LEN_*, DATA_*, CHECK: rx_ready = 1 (combinational from state); state advances only on xfer.
//   - After LEN_HI: N == 0 -> DONE (done = 1, download_program = 0, no writes).
//     N > MAX_WORDS -> ERR (error = 1, download_program = 0, no writes).
//   - DATA_HI xfer: instruction <= {rx_data, lo_byte}; wr_en = 1 for exactly the next cycle
//     with instruction_index = k for the k-th word (0-based); index increments after the strobe.
//   - Last write: instruction_index = N-1; no wrap, never exceeds MAX_WORDS-1.
//   - download_program falls in the same cycle done or error rises; the final wr_en
//     strobe occurs with download_program still high.
//   - Back-to-back bytes (rx_valid held high) accepted one per cycle, no bubbles.
//   - Reset mid-load: immediate return to IDLE, all outputs to reset values; partial
//     icache contents left as written.
// CONFIGURATION
//   LOADER_CHECKSUM_EN defined: one extra byte follows the last data byte (or LEN_HI
//     when N == 0); must equal XOR of all data bytes (length bytes excluded). CHECK state
//     consumes it; match -> DONE, mismatch -> ERR (words already written stay written).
//   LOADER_CHECKSUM_EN undefined: no CHECK state, no trailing byte; DONE follows last DATA_HI.
// TESTING
//   1. reset, start, bytes 02 00 34 12 78 56 -> wr_en @idx0=0x1234, @idx1=0x5678; done=1,
//      download_program high from cycle after start until done rises.
//   2. start, bytes 00 00 -> no wr_en, done=1 one cycle after LEN_HI xfer, error=0.
//   3. start, length 0x0101 (MAX_WORDS=256) -> error=1, download_program=0, no wr_en.
//   4. rx_valid toggled randomly during 4-word load -> same 4 writes at idx 0..3, rx_ready
//      never high in IDLE, no duplicate or dropped bytes.
//   5. reset asserted after 2nd data word -> all outputs 0 immediately; new start with
//      1 word writes at idx0.
//   6. LOADER_CHECKSUM_EN: 01 00 34 12 26 -> done=1; same with trailing 27 -> error=1.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream program loader feeding the icache write port.
// Ports: clk, reset (async, active-high), start; rx_valid/rx_data/rx_ready
//   byte input handshake; download_program (held during a load, gates the
//   CPU clock); wr_en/instruction_index/instruction icache write port;
//   done/error status levels of the last load.
// Optional: `define LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module program_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              download_program,
    output logic              wr_en,
    output logic [ADDR_W-1:0] instruction_index,
    output logic [15:0]       instruction,
    output logic              done,
    output logic              error
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN_LO,
        S_LEN_HI,
        S_DATA_LO,
        S_DATA_HI,
        S_FLUSH,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    state_t            state;
    state_t            next_state;
    logic [7:0]        len_lo;
    logic [7:0]        lo_byte;
    logic [15:0]       n_words;
    logic [15:0]       len;
    logic [ADDR_W-1:0] count;
    logic              xfer;
    logic              last;
    logic              idle;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum;
`endif

    assign len  = {rx_data, len_lo};
    assign xfer = rx_valid && rx_ready;
    assign last = (16'(count) == n_words - 16'd1);
    assign idle = (state == S_IDLE) || (state == S_DONE) ||
                  (state == S_ERR);

    assign rx_ready = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                      (state == S_DATA_LO) || (state == S_DATA_HI) ||
                      (state == S_CHECK);
    assign download_program = !idle;
    assign done  = (state == S_DONE);
    assign error = (state == S_ERR);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // S_FLUSH holds download_program for the cycle carrying the final
    // write strobe, so done rises only after the last icache write.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) next_state = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (xfer) next_state = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (xfer) begin
                    if (len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        next_state = S_CHECK;
`else
                        next_state = S_DONE;
`endif
                    end else if (len > MAX_N) begin
                        next_state = S_ERR;
                    end else begin
                        next_state = S_DATA_LO;
                    end
                end
            end
            S_DATA_LO: begin
                if (xfer) next_state = S_DATA_HI;
            end
            S_DATA_HI: begin
                if (xfer) begin
                    if (last) begin
`ifdef LOADER_CHECKSUM_EN
                        next_state = S_CHECK;
`else
                        next_state = S_FLUSH;
`endif
                    end else begin
                        next_state = S_DATA_LO;
                    end
                end
            end
            S_FLUSH: begin
                next_state = S_DONE;
            end
            S_CHECK: begin
`ifdef LOADER_CHECKSUM_EN
                if (xfer) begin
                    if (rx_data == csum) next_state = S_DONE;
                    else next_state = S_ERR;
                end
`else
                next_state = S_ERR;
`endif
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_en             <= 1'b0;
            instruction_index <= '0;
            instruction       <= '0;
            count             <= '0;
            n_words           <= '0;
            len_lo            <= '0;
            lo_byte           <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum              <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            if (idle && start) begin
                count             <= '0;
                instruction_index <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum              <= '0;
`endif
            end
            if (xfer) begin
                case (state)
                    S_LEN_LO: len_lo <= rx_data;
                    S_LEN_HI: n_words <= len;
                    S_DATA_LO: begin
                        lo_byte <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ rx_data;
`endif
                    end
                    S_DATA_HI: begin
                        instruction       <= {rx_data, lo_byte};
                        instruction_index <= count;
                        wr_en             <= 1'b1;
                        // Counter stops on the last word: no wrap past N-1.
                        if (!last) count <= count + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        csum <= csum ^ rx_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
